fsk_avalon_poll_master: RTL and testbench
=========================================

// Module: fsk_avalon_poll_master
// PURPOSE
//  Avalon-MM read initiator that periodically polls a 32-bit read-only input-port slave (2-bit word address).
//  Captured samples go into a first-word-fall-through FIFO and leave as a valid/ready stream toward the FSK demod/logging path.
//  It is the master-side counterpart of the SoC's registered-read PIO input slaves.
// PARAMETERS
//  TARGET_ADDR   2'd0  word address polled (data register of the input slave)
//  READ_LATENCY  1     fixed slave read latency in cycles, 1..4
//  FIFO_DEPTH    16    sample FIFO entries, power of 2, 4..256
//  DW            32    data width
// PORTS
//  clk            in   1        clock
//  reset_n        in   1        asynchronous, active-low reset
//  enable         in   1        polling enable
//  poll_period    in   16       cycles between read issues; 0 = back-to-back
//  avm_address    out  2        Avalon address, constant TARGET_ADDR
//  avm_read       out  1        Avalon read request
//  avm_waitrequest in  1        slave stall; tie 0 for PIO slaves
//  avm_readdata   in   DW       read data, valid READ_LATENCY cycles after accept
//  out_valid      out  1        FIFO head valid
//  out_ready      in   1        downstream accept
//  out_data       out  DW       FIFO head sample
//  fifo_level     out  log2(FIFO_DEPTH)+1  current occupancy
//  overflow       out  1        sticky: a sample was dropped
//  drop_count     out  16       dropped samples, saturating at 16'hFFFF
//  clr_ovf        in   1        synchronous clear of overflow and drop_count
// BEHAVIOUR
//  Reset: avm_read=0, avm_address=TARGET_ADDR, out_valid=0, fifo_level=0, overflow=0, drop_count=0, FSM=IDLE, timer=0.
//  FSM IDLE -> (enable) REQ; REQ -> (avm_read & !avm_waitrequest) LAT; LAT -> (lat_cnt==READ_LATENCY-1) CAP.
//  CAP -> WAIT if poll_period!=0, else REQ if enable, else IDLE.
//  WAIT: timer loads poll_period-1 on entry, decrements; at 0 -> REQ if enable, else IDLE.
//  poll_period is sampled on WAIT entry; mid-wait changes take effect on the next period.
//  avm_read is 1 only in REQ; address and read stay stable while avm_waitrequest=1.
//  Capture: avm_readdata is registered in the cycle the latency count expires.
//   Sample rate with poll_period=0 and waitrequest=0: one sample per READ_LATENCY+2 cycles.
//  A captured sample is pushed in the cycle after capture; push-to-out_valid latency is 1 cycle.
//  Push accepted if FIFO not full, or if full and pop in the same cycle (level unchanged).
//  Push into a full FIFO with no pop: sample dropped, overflow<=1, drop_count++ (saturating).
//  Pop when out_valid&out_ready; out_data is the head, stable while out_valid&!out_ready.
//  Simultaneous push+pop on an empty FIFO: no pop; the pushed sample appears next cycle.
//  clr_ovf coinciding with a drop: clear wins, then the count is 0 (drop not counted).
//  enable deasserted mid-transaction: the current read completes and its sample is pushed; no new read is issued.
//  Pointers wrap modulo FIFO_DEPTH; level distinguishes full from empty.
// CONFIGURATION
//  FSK_POLL_CHANGE_FILTER_EN defined: a sample is pushed only if it differs from the last captured sample.
//   The first sample after reset is always pushed; filtered samples never count as drops.
//  Undefined: every captured sample is pushed; no compare register exists.
// STRUCTURE
//  Package fsk_poll_pkg: FSM state enum (IDLE, REQ, LAT, CAP, WAIT), DW, AVM_AW=2, DROP_W=16.
//  Sub-module fsk_poll_fifo: FWFT sync FIFO (push, pop, full, empty, level).
//  Top level holds the FSM, period timer, latency counter, drop logic and optional change filter.
// TESTING
//  1. Reset with enable=1, poll_period=0, latency 1, slave returns 0xA5A5_0001 -> first avm_read 1 cycle after reset release; out_data=0xA5A5_0001.
//  2. poll_period=10, out_ready=1 -> avm_read pulses exactly 13 cycles apart (10+READ_LATENCY+2); no drops.
//  3. avm_waitrequest held 5 cycles -> avm_read and avm_address stable for 6 cycles; one sample captured.
//  4. out_ready=0, 20 polls, depth 16 -> fifo_level=16, overflow=1, drop_count=4; clr_ovf -> both 0; FIFO contents = first 16 samples in order.
//  5. enable dropped during LAT -> that sample is pushed, avm_read stays 0; reset_n asserted mid-REQ -> all outputs at reset values immediately.
//  6. With FSK_POLL_CHANGE_FILTER_EN, constant input 0x1234 polled 8 times -> one entry; change to 0x1235 -> second entry.

Source files
------------

// File: rtl/fsk_poll_pkg.sv
// Shared types and constants for the Avalon-MM polling master.
// Poll FSM states, bus widths and the saturating drop-counter helper.
`timescale 1ns/1ps
package fsk_poll_pkg;

  localparam int DW     = 32;
  localparam int AVM_AW = 2;
  localparam int DROP_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    LAT  = 3'd2,
    CAP  = 3'd3,
    WAIT = 3'd4
  } poll_state_t;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fsk_avalon_poll_master_if.sv
// Avalon-MM read channel plus the valid/ready sample stream of the poll master.
// The master modport is the poll master's view; slave is the PIO/sink side.
`timescale 1ns/1ps
interface fsk_avalon_poll_master_if #(
  parameter int DW = 32
);
  logic [fsk_poll_pkg::AVM_AW-1:0] avm_address;
  logic                            avm_read;
  logic                            avm_waitrequest;
  logic [DW-1:0]                   avm_readdata;
  logic                            out_valid;
  logic                            out_ready;
  logic [DW-1:0]                   out_data;

  modport master (
    output avm_address, avm_read, out_valid, out_data,
    input  avm_waitrequest, avm_readdata, out_ready
  );

  modport slave (
    input  avm_address, avm_read, out_valid, out_data,
    output avm_waitrequest, avm_readdata, out_ready
  );
endinterface

// File: rtl/fsk_poll_fifo.sv
// First-word-fall-through synchronous FIFO for captured samples.
// Head is read combinationally from the array; level separates full from empty.
`timescale 1ns/1ps
module fsk_poll_fifo #(
  parameter  int DW    = 32,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_pop_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [LW-1:0] o_level
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_wr;
  logic          w_rd;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign w_rd = i_pop && !o_empty;
  assign w_wr = i_push && (!o_full || w_rd);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  assign o_pop_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/fsk_avalon_poll_master.sv
// Avalon-MM poll master: periodic reads of a PIO input slave into a sample FIFO.
// Optional FSK_POLL_CHANGE_FILTER_EN pushes only samples that differ from the previous one.
`timescale 1ns/1ps
module fsk_avalon_poll_master #(
  parameter  logic [1:0] TARGET_ADDR  = 2'd0,
  parameter  int         READ_LATENCY = 1,
  parameter  int         FIFO_DEPTH   = 16,
  parameter  int         DW           = 32,
  localparam int         LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [15:0]                 poll_period,
  fsk_avalon_poll_master_if.master    bus,
  output logic [LVL_W-1:0]            fifo_level,
  output logic                        overflow,
  output logic [15:0]                 drop_count,
  input  logic                        clr_ovf
);

  import fsk_poll_pkg::*;

  localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

  poll_state_t         r_state;
  poll_state_t         w_state_next;
  logic [15:0]         r_timer;
  logic [2:0]          r_lat_cnt;
  logic [DW-1:0]       r_sample;
  logic                r_overflow;
  logic [DROP_W-1:0]   r_drop_count;
  logic                w_lat_done;
  logic                w_push;
  logic                w_fifo_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic                w_drop;

  assign w_lat_done = (r_state == LAT) && (r_lat_cnt == LAT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (enable) w_state_next = REQ;
      REQ:  if (!bus.avm_waitrequest) w_state_next = LAT;
      LAT:  if (w_lat_done) w_state_next = CAP;
      CAP: begin
        if (poll_period != 16'd0) w_state_next = WAIT;
        else if (enable)          w_state_next = REQ;
        else                      w_state_next = IDLE;
      end
      WAIT: if (r_timer == 16'd0) w_state_next = enable ? REQ : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Period is latched on WAIT entry so changes mid-wait apply to the next period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer   <= '0;
      r_lat_cnt <= '0;
      r_sample  <= '0;
    end else begin
      r_lat_cnt <= (r_state == LAT && !w_lat_done) ? r_lat_cnt + 3'd1 : 3'd0;
      if (r_state == CAP && poll_period != 16'd0) begin
        r_timer <= poll_period - 16'd1;
      end else if (r_state == WAIT && r_timer != 16'd0) begin
        r_timer <= r_timer - 16'd1;
      end
      if (w_lat_done) begin
        r_sample <= bus.avm_readdata;
      end
    end
  end

  assign bus.avm_read    = (r_state == REQ);
  assign bus.avm_address = TARGET_ADDR;

`ifdef FSK_POLL_CHANGE_FILTER_EN
  logic [DW-1:0] r_last;
  logic          r_last_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last       <= '0;
      r_last_valid <= 1'b0;
    end else if (r_state == CAP) begin
      r_last       <= r_sample;
      r_last_valid <= 1'b1;
    end
  end

  assign w_push = (r_state == CAP) && (!r_last_valid || (r_sample != r_last));
`else
  assign w_push = (r_state == CAP);
`endif

  assign bus.out_valid = !w_empty;
  assign w_pop         = bus.out_valid && bus.out_ready;
  assign w_fifo_push   = w_push && (!w_full || w_pop);
  assign w_drop        = w_push && w_full && !w_pop;

  // Clear takes priority, so a drop in the clearing cycle is not counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (clr_ovf) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow   <= 1'b1;
      r_drop_count <= sat_inc(r_drop_count);
    end
  end

  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

  fsk_poll_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_fifo_push),
    .i_push_data (r_sample),
    .i_pop       (w_pop),
    .o_pop_data  (bus.out_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (fifo_level)
  );

endmodule

// File: tb/tb_fsk_avalon_poll_master.sv
// Randomized bench for fsk_avalon_poll_master with a queue-based occupancy/drop model.
// Acts as the PIO slave (latency 1) and the downstream sink.
`timescale 1ns/1ps
module tb_fsk_avalon_poll_master;

  localparam int RL    = 1;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [15:0] poll_period = 16'd0;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic [15:0] drop_count;

  fsk_avalon_poll_master_if #(.DW(32)) bus();

  fsk_avalon_poll_master dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .poll_period (poll_period),
    .bus         (bus),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .drop_count  (drop_count),
    .clr_ovf     (clr_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int n_accepts = 0;
  bit use_const = 1'b0;
  logic [31:0] const_val = 32'h0;
  logic [31:0] issued[$];

  typedef struct { int due; logic [31:0] d; } pend_t;
  pend_t       pend[$];
  logic [31:0] mq[$];
  bit          m_ovf = 1'b0;
  int          m_drops = 0;
  bit          m_last_valid = 1'b0;
  logic [31:0] m_last = 32'h0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Slave: accept seen mid-cycle, data presented just after the accepting edge.
  initial forever begin
    logic [31:0] v;
    @(negedge clk);
    if (reset_n && bus.avm_read && !bus.avm_waitrequest) begin
      v = use_const ? const_val : $urandom;
      pend.push_back('{due: cyc + RL + 1, d: v});
      issued.push_back(v);
      n_accepts++;
      @(posedge clk);
      #1;
      bus.avm_readdata = v;
    end
  end

  // Reference model: sample enters the FIFO RL+1 cycles after its accept cycle.
  initial forever begin
    bit pop_now, push_now, full_before;
    logic [31:0] d;
    pend_t pe;
    @(negedge clk);
    if (mon_en) begin
      checks++;
      if (bus.out_valid !== (mq.size() != 0)) begin
        errors++;
        $display("FAIL mon_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, mq.size() != 0);
      end
      if (mq.size() != 0) begin
        checks++;
        if (bus.out_data !== mq[0]) begin
          errors++;
          $display("FAIL mon_data cyc=%0d got=%h exp=%h", cyc, bus.out_data, mq[0]);
        end
      end
      checks++;
      if (fifo_level !== 5'(mq.size())) begin
        errors++;
        $display("FAIL mon_level cyc=%0d got=%0d exp=%0d", cyc, fifo_level, mq.size());
      end
      checks++;
      if (overflow !== m_ovf || drop_count !== m_drops[15:0]) begin
        errors++;
        $display("FAIL mon_drops cyc=%0d got=%b/%0d exp=%b/%0d", cyc, overflow, drop_count, m_ovf, m_drops);
      end
      pop_now = (mq.size() != 0) && bus.out_ready;
      push_now = 1'b0;
      d = 32'h0;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        pe = pend.pop_front();
        d = pe.d;
        push_now = 1'b1;
`ifdef FSK_POLL_CHANGE_FILTER_EN
        if (m_last_valid && d == m_last) push_now = 1'b0;
        m_last = d;
        m_last_valid = 1'b1;
`endif
      end
      full_before = (mq.size() == DEPTH);
      if (pop_now) void'(mq.pop_front());
      if (push_now) begin
        if (!full_before || pop_now) begin
          mq.push_back(d);
        end else begin
          m_ovf = 1'b1;
          if (m_drops != 65535) m_drops++;
        end
      end
      if (clr_ovf) begin
        m_ovf = 1'b0;
        m_drops = 0;
      end
    end
  end

  task automatic drain();
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (30) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    repeat (DEPTH + 4) @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bit seen;
    enable = 1'b1; poll_period = 16'd0; bus.out_ready = 1'b0;
    use_const = 1'b1; const_val = 32'hA5A5_0001;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.avm_read !== 1'b0) begin errors++; $display("FAIL rst_read got=%b exp=0", bus.avm_read); end
    checks++; if (bus.avm_address !== 2'd0) begin errors++; $display("FAIL rst_addr got=%0d exp=0", bus.avm_address); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", bus.out_valid); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL rst_level got=%0d exp=0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL rst_drops got=%0d exp=0", drop_count); end
    @(negedge clk);
    reset_n = 1'b1;
    mon_en = 1'b1;
    #1;
    checks++; if (bus.avm_read !== 1'b0) begin errors++; $display("FAIL rel_read0 got=%b exp=0", bus.avm_read); end
    @(posedge clk); #1;
    checks++; if (bus.avm_read !== 1'b1) begin errors++; $display("FAIL first_read got=%b exp=1", bus.avm_read); end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL first_valid timeout got=0 exp=1"); end
    else if (bus.out_data !== 32'hA5A5_0001) begin errors++; $display("FAIL first_data got=%h exp=a5a50001", bus.out_data); end
    $display("test_reset first sample %h", bus.out_data);
    drain();
  endtask

  task automatic test_period();
    int t[$];
    bit prev;
    poll_period = 16'd10; use_const = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1 enable = 1'b1;
    prev = 1'b0;
    for (int i = 0; i < 100 && t.size() < 4; i++) begin
      @(negedge clk);
      if (bus.avm_read && !prev) t.push_back(cyc);
      prev = bus.avm_read;
    end
    checks++;
    if (t.size() != 4) begin
      errors++; $display("FAIL period_timeout got=%0d exp=4", t.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (t[i] - t[i-1] != 10 + RL + 2) begin
          errors++; $display("FAIL period_gap got=%0d exp=%0d", t[i] - t[i-1], 10 + RL + 2);
        end
        $display("test_period read gap %0d", t[i] - t[i-1]);
      end
    end
    checks++; if (drop_count !== 16'd0 || overflow !== 1'b0) begin errors++; $display("FAIL period_drops got=%0d exp=0", drop_count); end
    drain();
    poll_period = 16'd0;
  endtask

  task automatic test_waitrequest();
    int start;
    bit seen;
    bus.out_ready = 1'b0; bus.avm_waitrequest = 1'b1; poll_period = 16'd0;
    start = n_accepts;
    @(posedge clk); #1 enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.avm_read) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL wr_start timeout got=0 exp=1"); end
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      checks++; if (bus.avm_read !== 1'b1) begin errors++; $display("FAIL wr_read k=%0d got=%b exp=1", k, bus.avm_read); end
      checks++; if (bus.avm_address !== 2'd0) begin errors++; $display("FAIL wr_addr k=%0d got=%0d exp=0", k, bus.avm_address); end
      if (k == 4) begin
        @(posedge clk); #1 bus.avm_waitrequest = 1'b0;
      end
    end
    enable = 1'b0;
    @(negedge clk);
    checks++; if (bus.avm_read !== 1'b0) begin errors++; $display("FAIL wr_release got=%b exp=0", bus.avm_read); end
    repeat (10) @(posedge clk);
    #1;
    checks++; if (n_accepts - start != 1) begin errors++; $display("FAIL wr_accepts got=%0d exp=1", n_accepts - start); end
    checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL wr_level got=%0d exp=1", fifo_level); end
    $display("test_waitrequest accepts %0d level %0d", n_accepts - start, fifo_level);
    drain();
  endtask

  task automatic test_overflow();
    int start;
    int base;
    bus.out_ready = 1'b0; poll_period = 16'd0; use_const = 1'b0;
    start = n_accepts;
    base = issued.size();
    @(posedge clk); #1 enable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_accepts - start >= 20) break;
    end
    enable = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (n_accepts - start != 20) begin errors++; $display("FAIL ovf_polls got=%0d exp=20", n_accepts - start); end
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL ovf_level got=%0d exp=16", fifo_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    checks++; if (drop_count !== 16'd4) begin errors++; $display("FAIL ovf_drops got=%0d exp=4", drop_count); end
    $display("test_overflow level %0d overflow %b drops %0d", fifo_level, overflow, drop_count);
    @(posedge clk); #1 clr_ovf = 1'b1;
    @(posedge clk); #1 clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_flag got=%b exp=0", overflow); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL clr_drops got=%0d exp=0", drop_count); end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== issued[base + i]) begin
        errors++; $display("FAIL ovf_order i=%0d got=%b/%h exp=1/%h", i, bus.out_valid, bus.out_data, issued[base + i]);
      end
    end
    @(posedge clk); #1 bus.out_ready = 1'b0;
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL ovf_empty got=%0d exp=0", fifo_level); end
  endtask

  task automatic test_enable_drop_reset();
    int start;
    bit seen;
    bus.out_ready = 1'b0; poll_period = 16'd0;
    start = n_accepts;
    @(posedge clk); #1 enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.avm_read) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL en_start timeout got=0 exp=1"); end
    @(posedge clk); #1 enable = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++; if (bus.avm_read !== 1'b0) begin errors++; $display("FAIL en_noread i=%0d got=%b exp=0", i, bus.avm_read); end
    end
    checks++; if (n_accepts - start != 1) begin errors++; $display("FAIL en_accepts got=%0d exp=1", n_accepts - start); end
    checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL en_level got=%0d exp=1", fifo_level); end
    $display("test_enable_drop level %0d", fifo_level);
    bus.avm_waitrequest = 1'b1;
    @(posedge clk); #1 enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.avm_read) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstreq_start timeout got=0 exp=1"); end
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.avm_read !== 1'b0) begin errors++; $display("FAIL arst_read got=%b exp=0", bus.avm_read); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", bus.out_valid); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL arst_level got=%0d exp=0", fifo_level); end
    checks++; if (overflow !== 1'b0 || drop_count !== 16'd0) begin errors++; $display("FAIL arst_drops got=%b/%0d exp=0/0", overflow, drop_count); end
    enable = 1'b0;
    bus.avm_waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    mq.delete(); pend.delete();
    m_ovf = 1'b0; m_drops = 0; m_last_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    mon_en = 1'b1;
  endtask

`ifdef FSK_POLL_CHANGE_FILTER_EN
  task automatic test_filter();
    int start;
    bus.out_ready = 1'b0; poll_period = 16'd0;
    use_const = 1'b1; const_val = 32'h0000_1234;
    start = n_accepts;
    @(posedge clk); #1 enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (n_accepts - start >= 8) break;
    end
    enable = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL flt_const got=%0d exp=1", fifo_level); end
    checks++; if (bus.out_data !== 32'h0000_1234) begin errors++; $display("FAIL flt_data got=%h exp=00001234", bus.out_data); end
    const_val = 32'h0000_1235;
    start = n_accepts;
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (n_accepts - start >= 1) break;
    end
    enable = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (fifo_level !== 5'd2) begin errors++; $display("FAIL flt_change got=%0d exp=2", fifo_level); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL flt_drops got=%0d exp=0", drop_count); end
    $display("test_filter level %0d", fifo_level);
    use_const = 1'b0;
    drain();
  endtask
`endif

  task automatic test_random_stream();
    int start;
    bit prev_stall;
    use_const = 1'b0;
    start = n_accepts;
    prev_stall = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (bus.avm_read !== 1'b1 || bus.avm_address !== 2'd0) begin
          errors++; $display("FAIL rnd_stall cyc=%0d got=%b exp=1", cyc, bus.avm_read);
        end
      end
      prev_stall = bus.avm_read && bus.avm_waitrequest;
      @(posedge clk); #1;
      if (i % 64 == 0) poll_period = 16'($urandom_range(0, 3));
      enable = ($urandom_range(0, 19) != 0);
      bus.avm_waitrequest = ($urandom_range(0, 4) == 0);
      bus.out_ready = (i < 200) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 2) != 0);
      clr_ovf = ($urandom_range(0, 30) == 0);
    end
    bus.avm_waitrequest = 1'b0;
    clr_ovf = 1'b0;
    drain();
    #1;
    checks++; if (n_accepts - start < 50) begin errors++; $display("FAIL rnd_activity got=%0d exp>=50", n_accepts - start); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL rnd_drained got=%0d exp=0", fifo_level); end
    $display("test_random_stream reads %0d drops %0d", n_accepts - start, drop_count);
  endtask

  initial begin
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata = 32'h0;
    bus.out_ready = 1'b0;
    test_reset();
    test_period();
    test_waitrequest();
    test_overflow();
    test_enable_drop_reset();
`ifdef FSK_POLL_CHANGE_FILTER_EN
    test_filter();
`endif
    test_random_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
